// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first: one full-adder cell plus a carry flop, WIDTH cycles per add.
// Define SERIAL_ADDER_OVF_EN to add the registered two's-complement overflow output ovf.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             cout,
    output logic             ovf
`else
    output logic             cout
`endif
);

    localparam int CNT_W = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt;
    logic             carry_q;
    logic             cout_q;
    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;

    assign fa_sum   = a_sh[0] ^ b_sh[0] ^ carry_q;
    assign fa_cout  = (a_sh[0] & b_sh[0]) | (carry_q & (a_sh[0] ^ b_sh[0]));
    assign last_bit = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (last_bit) next_state = DONE;
            DONE:    next_state = start ? SHIFT : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operands are only captured when leaving IDLE/DONE, so input wiggles mid-add are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_q   <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh    <= a;
                        b_sh    <= b;
                        carry_q <= cin;
                        cnt     <= '0;
                    end
                end
                SHIFT: begin
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    sum_q   <= {fa_sum, sum_q[WIDTH-1:1]};
                    carry_q <= fa_cout;
                    cnt     <= cnt + 1'b1;
                    if (last_bit) cout_q <= fa_cout;
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;

    // On the final bit, carry_q is the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state == SHIFT && last_bit) begin
            ovf_q <= carry_q ^ fa_cout;
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy = (state == SHIFT);
    assign done = (state == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
// Checks reset, latency, wrap-around, ignored start, mid-add reset and back-to-back operation.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf;
`endif

    int total = 0;
    int bad   = 0;

    serial_adder #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
`ifdef SERIAL_ADDER_OVF_EN
        .cout  (cout),
        .ovf   (ovf)
`else
        .cout  (cout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Called at a negedge; start is sampled on the next rising edge.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts negedges until done, also counting busy cycles seen on the way.
    task automatic waitDone(output int n, output int busy_n);
        n      = 0;
        busy_n = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) busy_n++;
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n;
        int bn;
        int n2;
        bit saw_done;

        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        #1;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_sum", {24'd0, sum}, 32'h00);
        checkOutput("reset_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 0x0F + 0x01: latency and busy length
        applyStimulus(8'h0F, 8'h01, 1'b0);
        waitDone(n, bn);
        checkOutput("lat_0f01", n, 32'd8);
        checkOutput("busy_len_0f01", bn, 32'd8);
        checkOutput("sum_0f01", {24'd0, sum}, 32'h10);
        checkOutput("cout_0f01", {31'd0, cout}, 32'd0);
        @(negedge clk);
        checkOutput("done_pulse_0f01", {31'd0, done}, 32'd0);
        checkOutput("hold_sum_0f01", {24'd0, sum}, 32'h10);

        // Second start during SHIFT must be ignored
        applyStimulus(8'h01, 8'h01, 1'b0);
        repeat (2) @(negedge clk);
        a     = 8'h55;
        b     = 8'h55;
        cin   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(n, bn);
        checkOutput("lat_ignored", n, 32'd5);
        checkOutput("sum_ignored", {24'd0, sum}, 32'h02);
        checkOutput("cout_ignored", {31'd0, cout}, 32'd0);
        @(negedge clk);
        checkOutput("idle_after_ignored", {31'd0, busy}, 32'd0);

        // Wrap-around cases
        applyStimulus(8'hFF, 8'h01, 1'b0);
        waitDone(n, bn);
        checkOutput("sum_ff01", {24'd0, sum}, 32'h00);
        checkOutput("cout_ff01", {31'd0, cout}, 32'd1);
        @(negedge clk);
        applyStimulus(8'hFF, 8'hFF, 1'b1);
        waitDone(n, bn);
        checkOutput("sum_ffff1", {24'd0, sum}, 32'hFF);
        checkOutput("cout_ffff1", {31'd0, cout}, 32'd1);
        @(negedge clk);

`ifdef SERIAL_ADDER_OVF_EN
        applyStimulus(8'h7F, 8'h01, 1'b0);
        waitDone(n, bn);
        checkOutput("sum_7f01", {24'd0, sum}, 32'h80);
        checkOutput("ovf_7f01", {31'd0, ovf}, 32'd1);
        @(negedge clk);
        applyStimulus(8'h80, 8'h80, 1'b0);
        waitDone(n, bn);
        checkOutput("sum_8080", {24'd0, sum}, 32'h00);
        checkOutput("cout_8080", {31'd0, cout}, 32'd1);
        checkOutput("ovf_8080", {31'd0, ovf}, 32'd1);
        @(negedge clk);
        applyStimulus(8'h01, 8'h02, 1'b0);
        waitDone(n, bn);
        checkOutput("ovf_0102", {31'd0, ovf}, 32'd0);
        @(negedge clk);
        applyStimulus(8'hFF, 8'hFF, 1'b1);
        waitDone(n, bn);
        @(negedge clk);
`endif

        // Reset in the fourth SHIFT cycle (cout is still 1 from the previous add)
        applyStimulus(8'hFF, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("busy_before_rst", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_sum", {24'd0, sum}, 32'h00);
        checkOutput("rst_cout", {31'd0, cout}, 32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        checkOutput("no_done_after_rst", {31'd0, saw_done}, 32'd0);
        rst_n = 1'b1;
        applyStimulus(8'h12, 8'h34, 1'b1);
        checkOutput("busy_after_release", {31'd0, busy}, 32'd1);
        waitDone(n, bn);
        checkOutput("lat_after_rst", n, 32'd8);
        checkOutput("sum_after_rst", {24'd0, sum}, 32'h47);
        checkOutput("cout_after_rst", {31'd0, cout}, 32'd0);
        @(negedge clk);

        // Back-to-back: start held high, operands changed mid-add
        a     = 8'h03;
        b     = 8'h04;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        a     = 8'h10;
        b     = 8'h20;
        waitDone(n, bn);
        checkOutput("lat_b2b_first", n, 32'd8);
        checkOutput("sum_b2b_first", {24'd0, sum}, 32'h07);
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_b2b_reload", {31'd0, busy}, 32'd1);
        waitDone(n2, bn);
        checkOutput("gap_b2b", n2 + 1, 32'd9);
        checkOutput("sum_b2b_second", {24'd0, sum}, 32'h30);
        checkOutput("cout_b2b_second", {31'd0, cout}, 32'd0);
        @(negedge clk);
        checkOutput("idle_after_b2b", {31'd0, busy | done}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning the operand and result width in bits (legal range 2..32).
REQ-002 Port clk SHALL be input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port rst_n SHALL be input, 1 bit: asynchronous reset, active-low.
REQ-004 Port start SHALL be input, 1 bit: request to begin an addition; sampled only when busy=0.
REQ-005 Port a SHALL be input, WIDTH bits: operand A, sampled with start.
REQ-006 Port b SHALL be input, WIDTH bits: operand B, sampled with start.
REQ-007 Port cin SHALL be input, 1 bit: carry into bit 0, sampled with start.
REQ-008 Port busy SHALL be output, 1 bit: high while an addition is in progress.
REQ-009 Port done SHALL be output, 1 bit: single-cycle pulse when sum/cout become valid.
REQ-010 Port sum SHALL be output, WIDTH bits: registered result.
REQ-011 Port cout SHALL be output, 1 bit: registered carry out of bit WIDTH-1.

Function
REQ-012 The addition SHALL be bit-serial, LSB first, using exactly one 1-bit full-adder cell (inputs a, b, carry_in; outputs sum, carry_out) plus a 1-bit carry register.
REQ-013 The FSM SHALL have states IDLE, SHIFT, DONE; busy=1 only in SHIFT.
REQ-014 IDLE->SHIFT on start=1: load operand shift registers with a, b; carry register <= cin; bit counter <= 0.
REQ-015 In each SHIFT cycle, the cell SHALL add operand bit 0 of each register with the carry register; the result bit shifts into the sum register MSB, the operands shift right by one, and the carry register <= carry_out.
REQ-016 SHIFT->DONE SHALL occur after exactly WIDTH SHIFT cycles (counter reaches WIDTH-1); the counter width is $clog2(WIDTH) rounded up to at least 1 bit.
REQ-017 On the SHIFT->DONE edge, sum SHALL hold the complete result and cout the final carry; done=1 for exactly the DONE cycle.
REQ-018 Latency: if start is sampled at edge k, done SHALL be high in the cycle following edge k+WIDTH.
REQ-019 DONE->SHIFT on start=1 (back-to-back, new operands loaded); otherwise DONE->IDLE.
REQ-020 start while busy=1 SHALL be ignored; a, b, cin changes during SHIFT SHALL NOT affect the result.
REQ-021 sum and cout SHALL hold their last valid values in IDLE until the next DONE; intermediate sum bits are visible during SHIFT and are not guaranteed valid.
REQ-022 Wrap-around SHALL be modulo 2^WIDTH, with the carry reported on cout (e.g. 0xFF+0x01 -> sum 0x00, cout 1).

Reset
REQ-023 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry and operand registers=0, independent of clk.
REQ-024 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; after release, the block SHALL accept start on the first rising edge.

Configuration
REQ-025 Macro SERIAL_ADDER_OVF_EN, when defined, SHALL add output port ovf (1 bit, reset 0), registered on the SHIFT->DONE edge as the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1 (two's-complement overflow) and held like sum.
REQ-026 Without SERIAL_ADDER_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-027 a=0x0F, b=0x01, cin=0, start pulse -> done high 8 cycles after the start edge, sum=0x10, cout=0; busy high for exactly 8 cycles.
REQ-028 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-029 With SERIAL_ADDER_OVF_EN: a=0x7F, b=0x01 -> sum=0x80, ovf=1; a=0x80, b=0x80 -> sum=0x00, cout=1, ovf=1.
REQ-030 start with a=0x01, b=0x01, then start with a=0x55 at cycle 3 -> second start ignored; sum=0x02 at done.
REQ-031 Assert rst_n low at SHIFT cycle 4 -> all outputs immediately 0, no done pulse; new start after release -> correct result 8 cycles later.
REQ-032 start held high through DONE with new operands 0x10+0x20 -> second done exactly 9 cycles after the first, sum=0x30.
